// File: rtl/wb_pkg.sv
// Shared definitions for the write-back port arbiter: FSM encoding, write-source
// codes and the register-address width.
package wb_pkg;

    localparam int unsigned RegAddrW = 5;

    // Source codes reported on rf_src
    localparam logic SRC_PIPE = 1'b0;
    localparam logic SRC_MC   = 1'b1;

    typedef enum logic {
        StNormal = 1'b0,
        StStarve = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_pend_fifo.sv
// Two-entry buffer of {rd, data} beats from the multi-cycle unit. The head is
// read combinationally; push and pop may coincide, including when full.
module wb_pend_fifo
    import wb_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [RegAddrW-1:0] push_rd_i,
    input  logic [width-1:0]    push_data_i,
    input  logic                pop_i,
    output logic [RegAddrW-1:0] head_rd_o,
    output logic [width-1:0]    head_data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [1:0]          count_o
);

    logic                          wr_ptr_q, wr_ptr_d;
    logic                          rd_ptr_q, rd_ptr_d;
    logic [1:0]                    count_q, count_d;
    logic [1:0][RegAddrW-1:0]      mem_rd_q, mem_rd_d;
    logic [1:0][width-1:0]         mem_data_q, mem_data_d;
    logic                          push_ok, pop_ok;

    assign full_o      = (count_q == 2'd2);
    assign empty_o     = (count_q == 2'd0);
    assign count_o     = count_q;
    assign head_rd_o   = mem_rd_q[rd_ptr_q];
    assign head_data_o = mem_data_q[rd_ptr_q];

    // Pointer, count and storage next-state; a push into a full buffer is
    // only legal when the head leaves in the same cycle.
    always_comb begin
        push_ok    = push_i & (~full_o | pop_i);
        pop_ok     = pop_i & ~empty_o;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        if (push_ok) begin
            mem_rd_d[wr_ptr_q]   = push_rd_i;
            mem_data_d[wr_ptr_q] = push_data_i;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            mem_rd_q   <= '0;
            mem_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_rd_q   <= mem_rd_d;
            mem_data_q <= mem_data_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// write-back stage (always wins) and a buffered multi-cycle unit. A starvation
// FSM requests a pipeline stall when the buffered results keep losing.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned width        = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_valid,
    input  logic                wb_regwrite,
    input  logic [RegAddrW-1:0] wb_rd,
    input  logic [width-1:0]    wb_data,
    input  logic                mc_valid,
    output logic                mc_ready,
    input  logic [RegAddrW-1:0] mc_rd,
    input  logic [width-1:0]    mc_data,
    output logic                rf_we,
    output logic [RegAddrW-1:0] rf_rd,
    output logic [width-1:0]    rf_wd,
    output logic                rf_src,
    output logic                stall_req,
    output logic [1:0]          pend_cnt
);

    // Limits above the 3-bit counter range are clamped to its saturation value
    localparam logic [2:0] StarveLim = (STARVE_LIMIT > 7) ? 3'd7 : 3'(STARVE_LIMIT);

    logic                pipe_req, grant_mc, mc_push;
    logic                fifo_full, fifo_empty;
    logic [RegAddrW-1:0] head_rd;
    logic [width-1:0]    head_data;

    logic                rf_we_q, rf_we_d;
    logic [RegAddrW-1:0] rf_rd_q, rf_rd_d;
    logic [width-1:0]    rf_wd_q, rf_wd_d;
    logic                rf_src_q, rf_src_d;
    wb_state_e           state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;

    assign pipe_req = wb_valid & wb_regwrite;
    // No empty bypass: the buffer head is only granted once it is stored
    assign grant_mc = ~pipe_req & ~fifo_empty;
    assign mc_ready = ~fifo_full;
    assign mc_push  = mc_valid & mc_ready;

    wb_pend_fifo #(
        .width (width)
    ) u_pend_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (mc_push),
        .push_rd_i   (mc_rd),
        .push_data_i (mc_data),
        .pop_i       (grant_mc),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (pend_cnt)
    );

    // Write-port selection; address, data and source hold when nothing is granted
    always_comb begin
        rf_we_d  = 1'b0;
        rf_rd_d  = rf_rd_q;
        rf_wd_d  = rf_wd_q;
        rf_src_d = rf_src_q;
        if (pipe_req) begin
            rf_we_d  = |wb_rd;
            rf_rd_d  = wb_rd;
            rf_wd_d  = wb_data;
            rf_src_d = SRC_PIPE;
        end else if (grant_mc) begin
            rf_we_d  = |head_rd;
            rf_rd_d  = head_rd;
            rf_wd_d  = head_data;
            rf_src_d = SRC_MC;
        end
    end

    // Starvation FSM: count consecutive losses of a waiting head to the pipeline
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StNormal: begin
                if (fifo_empty || grant_mc) begin
                    cnt_d = 3'd0;
                end else begin
                    if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
                    if (cnt_d >= StarveLim) state_d = StStarve;
                end
            end
            StStarve: begin
                if (grant_mc) begin
                    state_d = StNormal;
                    cnt_d   = 3'd0;
                end
            end
            default: begin
                state_d = StNormal;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q  <= 1'b0;
            rf_rd_q  <= '0;
            rf_wd_q  <= '0;
            rf_src_q <= SRC_PIPE;
            state_q  <= StNormal;
            cnt_q    <= 3'd0;
        end else begin
            rf_we_q  <= rf_we_d;
            rf_rd_q  <= rf_rd_d;
            rf_wd_q  <= rf_wd_d;
            rf_src_q <= rf_src_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_rd     = rf_rd_q;
    assign rf_wd     = rf_wd_q;
    assign rf_src    = rf_src_q;
    assign stall_req = (state_q == StStarve);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, pipeline writes, buffered writes,
// back-pressure with ordering, starvation stall, rd=0 suppression, mid-run reset.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        rf_src;
    logic        stall_req;
    logic [1:0]  pend_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .width        (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .mc_valid    (mc_valid),
        .mc_ready    (mc_ready),
        .mc_rd       (mc_rd),
        .mc_data     (mc_data),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wd       (rf_wd),
        .rf_src      (rf_src),
        .stall_req   (stall_req),
        .pend_cnt    (pend_cnt)
    );

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
        mc_valid = 1'b0; mc_rd = '0; mc_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0h exp=0", rf_we); end
        checks++; if (rf_rd !== 5'd0) begin failures++; $display("FAIL reset_rf_rd got=%0h exp=0", rf_rd); end
        checks++; if (rf_wd !== 32'd0) begin failures++; $display("FAIL reset_rf_wd got=%0h exp=0", rf_wd); end
        checks++; if (rf_src !== 1'b0) begin failures++; $display("FAIL reset_rf_src got=%0h exp=0", rf_src); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall_req); end
        checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL reset_pend got=%0h exp=0", pend_cnt); end
        tick();
        checks++; if (mc_ready !== 1'b1) begin failures++; $display("FAIL reset_mc_ready got=%0h exp=1", mc_ready); end
    endtask

    task automatic test_pipe_write();
        wb_valid = 1'b1; wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL pipe_we got=%0h exp=1", rf_we); end
        checks++; if (rf_rd !== 5'd5) begin failures++; $display("FAIL pipe_rd got=%0h exp=5", rf_rd); end
        checks++; if (rf_wd !== 32'hDEADBEEF) begin failures++; $display("FAIL pipe_wd got=%0h exp=deadbeef", rf_wd); end
        checks++; if (rf_src !== 1'b0) begin failures++; $display("FAIL pipe_src got=%0h exp=0", rf_src); end
        // valid without regwrite is not a request
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h1111;
        tick();
        idle_inputs();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL pipe_noreg_we got=%0h exp=0", rf_we); end
        checks++; if (rf_rd !== 5'd5) begin failures++; $display("FAIL pipe_hold_rd got=%0h exp=5", rf_rd); end
        checks++; if (rf_wd !== 32'hDEADBEEF) begin failures++; $display("FAIL pipe_hold_wd got=%0h exp=deadbeef", rf_wd); end
    endtask

    task automatic test_mc_single();
        mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h12;
        checks++; if (mc_ready !== 1'b1) begin failures++; $display("FAIL mc1_ready got=%0h exp=1", mc_ready); end
        tick();
        idle_inputs();
        checks++; if (pend_cnt !== 2'd1) begin failures++; $display("FAIL mc1_pend got=%0h exp=1", pend_cnt); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mc1_nobypass got=%0h exp=0", rf_we); end
        tick();
        checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL mc1_we got=%0h exp=1", rf_we); end
        checks++; if (rf_rd !== 5'd7) begin failures++; $display("FAIL mc1_rd got=%0h exp=7", rf_rd); end
        checks++; if (rf_wd !== 32'h12) begin failures++; $display("FAIL mc1_wd got=%0h exp=12", rf_wd); end
        checks++; if (rf_src !== 1'b1) begin failures++; $display("FAIL mc1_src got=%0h exp=1", rf_src); end
        checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL mc1_pend0 got=%0h exp=0", pend_cnt); end
    endtask

    // Pipeline writes every cycle while three beats arrive; the third waits,
    // the head loses four times and the stall is raised.
    task automatic test_back_to_back();
        logic [1:0] exp_pend;
        int         b;
        for (int i = 0; i < 5; i++) begin
            b = (i < 2) ? i : 2;
            wb_valid = 1'b1; wb_regwrite = 1'b1;
            wb_rd = 5'(i + 1); wb_data = 32'h100 + 32'(i);
            mc_valid = 1'b1; mc_rd = 5'(10 + b); mc_data = 32'hA0 + 32'(b);
            checks++; if (mc_ready !== (i < 2)) begin failures++; $display("FAIL b2b_ready[%0d] got=%0h exp=%0h", i, mc_ready, (i < 2)); end
            tick();
            exp_pend = (i == 0) ? 2'd1 : 2'd2;
            checks++; if (pend_cnt !== exp_pend) begin failures++; $display("FAIL b2b_pend[%0d] got=%0h exp=%0h", i, pend_cnt, exp_pend); end
            checks++; if (rf_rd !== 5'(i + 1) || rf_src !== 1'b0 || rf_we !== 1'b1) begin failures++; $display("FAIL b2b_pipe[%0d] got rd=%0h src=%0h we=%0h exp rd=%0h src=0 we=1", i, rf_rd, rf_src, rf_we, i + 1); end
            checks++; if (stall_req !== (i == 4)) begin failures++; $display("FAIL b2b_stall[%0d] got=%0h exp=%0h", i, stall_req, (i == 4)); end
        end
        // In-flight pipeline write still wins during the stall
        wb_rd = 5'd6; wb_data = 32'h106;
        tick();
        checks++; if (rf_rd !== 5'd6 || rf_src !== 1'b0) begin failures++; $display("FAIL starve_pipe got rd=%0h src=%0h exp rd=6 src=0", rf_rd, rf_src); end
        checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL starve_hold got=%0h exp=1", stall_req); end
        checks++; if (pend_cnt !== 2'd2) begin failures++; $display("FAIL starve_pend got=%0h exp=2", pend_cnt); end
        // Pipeline idle: head beat 0 granted, stall drops next cycle
        wb_valid = 1'b0; wb_regwrite = 1'b0;
        tick();
        checks++; if (rf_rd !== 5'd10 || rf_wd !== 32'hA0 || rf_src !== 1'b1) begin failures++; $display("FAIL order0 got rd=%0h wd=%0h src=%0h exp rd=a wd=a0 src=1", rf_rd, rf_wd, rf_src); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL starve_exit got=%0h exp=0", stall_req); end
        checks++; if (pend_cnt !== 2'd1) begin failures++; $display("FAIL order0_pend got=%0h exp=1", pend_cnt); end
        // Beat 2 pushes while beat 1 pops
        checks++; if (mc_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_again got=%0h exp=1", mc_ready); end
        tick();
        mc_valid = 1'b0;
        checks++; if (rf_rd !== 5'd11 || rf_wd !== 32'hA1) begin failures++; $display("FAIL order1 got rd=%0h wd=%0h exp rd=b wd=a1", rf_rd, rf_wd); end
        checks++; if (pend_cnt !== 2'd1) begin failures++; $display("FAIL pushpop_pend got=%0h exp=1", pend_cnt); end
        tick();
        checks++; if (rf_rd !== 5'd12 || rf_wd !== 32'hA2 || rf_we !== 1'b1) begin failures++; $display("FAIL order2 got rd=%0h wd=%0h we=%0h exp rd=c wd=a2 we=1", rf_rd, rf_wd, rf_we); end
        checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL order2_pend got=%0h exp=0", pend_cnt); end
        idle_inputs();
    endtask

    task automatic test_rd_zero();
        mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'h55;
        tick();
        idle_inputs();
        checks++; if (pend_cnt !== 2'd1) begin failures++; $display("FAIL rd0_pend1 got=%0h exp=1", pend_cnt); end
        tick();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rd0_we got=%0h exp=0", rf_we); end
        checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL rd0_pend0 got=%0h exp=0", pend_cnt); end
        // Pipeline write to x0 is likewise suppressed
        wb_valid = 1'b1; wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 32'h77;
        tick();
        idle_inputs();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rd0_pipe_we got=%0h exp=0", rf_we); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1'b1; wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 32'h300 + 32'(i);
            mc_valid = (i < 2); mc_rd = 5'(20 + i); mc_data = 32'hC0 + 32'(i);
            tick();
        end
        checks++; if (stall_req !== 1'b1 || pend_cnt !== 2'd2) begin failures++; $display("FAIL pre_rst got stall=%0h pend=%0h exp stall=1 pend=2", stall_req, pend_cnt); end
        // Reset wins over a simultaneous pipeline write
        rst = 1'b1;
        tick();
        checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL rst_mid_pend got=%0h exp=0", pend_cnt); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got=%0h exp=0", stall_req); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_mid_we got=%0h exp=0", rf_we); end
        checks++; if (mc_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%0h exp=1", mc_ready); end
        checks++; if (rf_rd !== 5'd0 || rf_wd !== 32'd0) begin failures++; $display("FAIL rst_mid_rf got rd=%0h wd=%0h exp 0 0", rf_rd, rf_wd); end
        rst = 1'b0;
        idle_inputs();
        tick();
        checks++; if (rf_we !== 1'b0 || pend_cnt !== 2'd0) begin failures++; $display("FAIL rst_discard got we=%0h pend=%0h exp 0 0", rf_we, pend_cnt); end
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_mc_single();
        test_back_to_back();
        test_rd_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter `width`, default 32: data width of the register-file write port.
REQ-002 Parameter `STARVE_LIMIT`, default 4: consecutive lost arbitration cycles before a pipeline stall is forced.
REQ-003 `clk  in  1`: single clock; all state updates on the rising edge.
REQ-004 `rst  in  1`: reset, synchronous, active-high.
REQ-005 `wb_valid  in  1`: pipeline write-back stage has a result this cycle.
REQ-006 `wb_regwrite  in  1`: pipeline result writes the register file.
REQ-007 `wb_rd  in  5`: pipeline destination register.
REQ-008 `wb_data  in  width`: pipeline result, already selected by the write-back result mux.
REQ-009 `mc_valid  in  1`: multi-cycle unit (divider or late load) offers a result.
REQ-010 `mc_ready  out  1`: arbiter accepts the mc_* beat this cycle.
REQ-011 `mc_rd  in  5`: multi-cycle unit destination register.
REQ-012 `mc_data  in  width`: multi-cycle unit result.
REQ-013 `rf_we  out  1`: register-file write enable, registered.
REQ-014 `rf_rd  out  5`: register-file write address, registered.
REQ-015 `rf_wd  out  width`: register-file write data, registered.
REQ-016 `rf_src  out  1`: source of the current write; 0 = pipeline, 1 = multi-cycle unit.
REQ-017 `stall_req  out  1`: request to the hazard unit to freeze the pipeline.
REQ-018 `pend_cnt  out  2`: occupancy of the multi-cycle buffer, 0..2.

Function
REQ-019 A 2-entry FIFO SHALL hold {rd, data} pairs from the multi-cycle unit; `mc_ready` = (pend_cnt < 2).
REQ-020 An mc beat SHALL be accepted when `mc_valid` and `mc_ready` are both high.
REQ-021 A pipeline request exists when `wb_valid & wb_regwrite` is high.
REQ-022 A pipeline request SHALL always win arbitration; it is never dropped or delayed.
REQ-023 When no pipeline request exists and the FIFO is non-empty, the FIFO head SHALL be granted and popped.
REQ-024 Push and pop in the same cycle SHALL leave the count unchanged and preserve FIFO order, including when the FIFO is full.
REQ-025 An empty-FIFO bypass SHALL NOT exist; an accepted mc beat is first eligible for grant in the following cycle.
REQ-026 The granted write SHALL appear on rf_we/rf_rd/rf_wd/rf_src one cycle after grant (latency 1).
REQ-027 A granted write with rd = 0 SHALL be consumed, but `rf_we` SHALL be 0 for it.
REQ-028 With no grant, `rf_we` SHALL be 0; rf_rd, rf_wd and rf_src SHALL hold their previous values.
REQ-029 The FSM SHALL have two states, NORMAL and STARVE; its starve counter is 3 bits wide and saturates.
REQ-030 In NORMAL, the counter increments each cycle the FIFO is non-empty and a pipeline request wins.
  - It resets to 0 whenever the FIFO head is granted or the FIFO is empty.
REQ-031 NORMAL SHALL move to STARVE when the counter reaches STARVE_LIMIT.
REQ-032 In STARVE, `stall_req` SHALL be 1; in NORMAL it SHALL be 0 (Moore output).
REQ-033 STARVE SHALL return to NORMAL, clearing the counter, in the cycle after the FIFO head is granted.
REQ-034 In STARVE, a pipeline request still present (in-flight before the stall) SHALL still win; the stall remains asserted.
REQ-035 Write ordering between the two sources for the same rd is the scoreboard's responsibility; this block performs no rd comparison.

Reset
REQ-036 On `rst`, the following SHALL all be forced to 0: FIFO pointers and count, FSM (to NORMAL), starve counter, rf_we, rf_rd, rf_wd, rf_src and stall_req.
REQ-037 Reset SHALL take priority over every simultaneous push, grant or state transition, and discards buffered entries mid-operation.
REQ-038 `mc_ready` SHALL read 1 in the first cycle after reset deasserts.

Structure
REQ-039 Shared package `wb_pkg` SHALL hold the FSM state encoding, the source codes (SRC_PIPE = 0, SRC_MC = 1) and the register-address width constant 5.
REQ-040 The 2-entry buffer SHALL be a sub-module `wb_pend_fifo`, parameterised on width, exposing push, pop, full, empty and count.
REQ-041 Arbitration and output registers SHALL reside in the top module.

Verification
REQ-042 After reset, a pipeline write rd = 5, data = 0xDEADBEEF -> next cycle rf_we = 1, rf_rd = 5, rf_wd = 0xDEADBEEF, rf_src = 0.
REQ-043 mc beat rd = 7, data = 0x12 with the pipeline idle -> pend_cnt = 1 after one cycle; rf_we = 1, rf_rd = 7, rf_src = 1 after two cycles.
REQ-044 Three mc beats back-to-back with the pipeline writing every cycle -> mc_ready = 0 on the third beat; pend_cnt stays 2; no beat is lost or reordered.
REQ-045 FIFO non-empty with the pipeline writing continuously, STARVE_LIMIT = 4 -> stall_req = 1 from the cycle after the 4th loss, deasserting one cycle after the head is granted.
REQ-046 A granted mc write with rd = 0 -> rf_we = 0 and pend_cnt decrements.
REQ-047 rst asserted with pend_cnt = 2 in STARVE -> next cycle pend_cnt = 0, stall_req = 0, rf_we = 0, mc_ready = 1.
